counter_mod_n: RTL and testbench
================================

COUNTER_MOD_N -- requirements
Module: counter_mod_n

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter register width in bits, legal range 1..32.
REQ-002 SHALL have parameter MODULUS, default 16: count range 0..MODULUS-1, legal range 2..2**WIDTH.
REQ-003 SHALL have parameter SATURATE, default 0: 0 = wrap at terminal count, 1 = hold at terminal count.
REQ-004 SHALL have port clk  input  1: single clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1: asynchronous, active-high reset.
REQ-006 SHALL have port ce  input  1: count enable.
REQ-007 SHALL have port ci  input  1: cascade carry-in; counting requires ce=1 and ci=1; tie to 1 when unused.
REQ-008 SHALL have port up  input  1: direction, 1 = increment, 0 = decrement.
REQ-009 SHALL have port load  input  1: synchronous parallel load strobe.
REQ-010 SHALL have port din  input  WIDTH: parallel load value.
REQ-011 SHALL have port ovf_clr  input  1: synchronous clear of sticky overflow flag.
REQ-012 SHALL have port q  output  WIDTH: registered count value.
REQ-013 SHALL have port rc  output  1: combinational ripple carry to the next stage's ci.
REQ-014 SHALL have port ovf  output  1: registered sticky terminal-crossing flag.

Function
REQ-015 SHALL apply priority per clock edge: rst > load > count > hold.
REQ-016 SHALL, on load=1, set q <= din when din < MODULUS, else q <= MODULUS-1 (clamp), regardless of ce/ci/up.
REQ-017 SHALL treat "step" as ce=1 & ci=1 & load=0; no step means q holds.
REQ-018 SHALL, on up step with q < MODULUS-1, set q <= q+1; with q = MODULUS-1, set q <= 0 (SATURATE=0) or hold (SATURATE=1).
REQ-019 SHALL, on down step with q > 0, set q <= q-1; with q = 0, set q <= MODULUS-1 (SATURATE=0) or hold (SATURATE=1).
REQ-020 SHALL drive rc = ce & ci & (up ? q==MODULUS-1 : q==0), same-cycle, independent of load and SATURATE.
REQ-021 SHALL define a terminal event as a step taken while rc=1; it sets ovf on that edge in both SATURATE modes.
REQ-022 SHALL clear ovf on load=1 or ovf_clr=1 unless a terminal event occurs on the same edge; set wins over ovf_clr, and load always clears because load suppresses the step.
REQ-023 SHALL never produce q >= MODULUS from any sequence of inputs, including a direction change at terminal count.
REQ-024 SHALL allow cascading: stage k's rc drives stage k+1's ci with common ce/up/clk, giving a MODULUS**n counter with no added latency.
REQ-025 SHALL have a one-edge latency from any input to q and ovf; rc has zero latency from q, ce, ci, up.

Reset
REQ-026 SHALL, while rst=1, force q=0 and ovf=0 immediately, independent of clk.
REQ-027 SHALL make rc reflect reset state combinationally: rc = ce & ci & ~up when MODULUS>1 and q=0.
REQ-028 SHALL resume counting from 0 on the first rising clk edge after rst deasserts; rst asserted mid-count discards the count and the ovf flag.

Verification
REQ-029 SHALL cover: WIDTH=4, MODULUS=10, SATURATE=0, up=1, ce=ci=1 for 12 edges from reset -> q = 1..9,0,1,2; rc=1 only while q=9; ovf=1 from edge 10.
REQ-030 SHALL cover: MODULUS=10, SATURATE=1, up=0 from q=2 for 4 edges -> q=1,0,0,0; ovf set on edge 3; ovf_clr with step at q=0 -> ovf stays 1.
REQ-031 SHALL cover: load=1, din=13 with MODULUS=10 -> q=9; load=1, din=4 with ce=1 at the same time -> q=4 and ovf=0.
REQ-032 SHALL cover: two cascaded MODULUS=10 stages, up count 100 edges from reset -> {hi,lo} sequences 00..99 then 00; hi steps only on edges where lo=9.
REQ-033 SHALL cover: rst asserted between clk edges at q=7, ovf=1 -> q=0 and ovf=0 before the next edge; first post-reset up step -> q=1.
REQ-034 SHALL cover: ci=0 with ce=1 for 5 edges at q=3 -> q holds 3 and rc=0; MODULUS=16, WIDTH=4 full-range wrap 15->0 sets ovf.

Source files
------------

// File: rtl/counter_mod_n_if.sv
`default_nettype none
// ============================================================================
//  Module      : counter_mod_n_if
//  Description : Control/status bundle for one counter_mod_n stage.
//                master modport = controller (drives controls, reads status)
//                slave  modport = counter    (reads controls, drives status)
//  Signals     : ce, ci, up, load, din[WIDTH], ovf_clr  -> counter
//                q[WIDTH], rc, ovf                      <- counter
//  Revision    : 1.0  initial release
// ============================================================================
interface counter_mod_n_if #(
  parameter int WIDTH = 4
);
  logic             ce;
  logic             ci;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] din;
  logic             ovf_clr;
  logic [WIDTH-1:0] q;
  logic             rc;
  logic             ovf;

  modport master (
    output ce, ci, up, load, din, ovf_clr,
    input  q, rc, ovf
  );

  modport slave (
    input  ce, ci, up, load, din, ovf_clr,
    output q, rc, ovf
  );
endinterface
`default_nettype wire

// File: rtl/counter_mod_n.sv
`default_nettype none
// ============================================================================
//  Module      : counter_mod_n
//  Description : Cascadable up/down modulo-MODULUS counter with parallel
//                load (clamped to MODULUS-1), optional saturation at the
//                terminal count, combinational ripple carry and a sticky
//                terminal-crossing flag.
//  Ports       : clk  - rising-edge clock
//                rst  - asynchronous active-high reset
//                bus  - counter_mod_n_if.slave
//                       ce/ci  count enable / cascade carry-in
//                       up     direction (1 = increment)
//                       load/din  parallel load
//                       ovf_clr   clear of sticky ovf
//                       q      registered count
//                       rc     ripple carry (to next stage ci)
//                       ovf    sticky terminal-crossing flag
//  Revision    : 1.0  initial release
// ============================================================================
module counter_mod_n #(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MODULUS  = 16,
  parameter int              SATURATE = 0
) (
  input wire             clk,
  input wire             rst,
  counter_mod_n_if.slave bus
);

  localparam logic [WIDTH-1:0] C_TERM = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);
  localparam bit               C_SAT  = (SATURATE != 0);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             ovf_q;
  logic             ovf_d;

  logic             w_at_top;
  logic             w_at_bot;
  logic             w_rc;
  logic             w_step;
  logic             w_din_ok;

  assign w_at_top = (q_q == C_TERM);
  assign w_at_bot = (q_q == '0);

  // Ripple carry ignores load and SATURATE so a cascade sees the same
  // carry regardless of how the stage is configured.
  assign w_rc     = bus.ce & bus.ci & (bus.up ? w_at_top : w_at_bot);
  assign w_step   = bus.ce & bus.ci & ~bus.load;

  // Compare in 64 bits so MODULUS = 2**WIDTH (incl. WIDTH = 32) is exact.
  assign w_din_ok = ({{(64-WIDTH){1'b0}}, bus.din} < MODULUS);

  always_comb begin
    q_d   = q_q;
    ovf_d = ovf_q;

    if (bus.load) begin
      q_d = w_din_ok ? bus.din : C_TERM;
    end else if (w_step) begin
      if (bus.up) begin
        if (w_at_top) q_d = C_SAT ? q_q : '0;
        else          q_d = q_q + C_ONE;
      end else begin
        if (w_at_bot) q_d = C_SAT ? q_q : C_TERM;
        else          q_d = q_q - C_ONE;
      end
    end

    // Clear first, then a terminal event on the same edge overrides it.
    // Load suppresses the step, so a load always leaves ovf cleared.
    if (bus.load || bus.ovf_clr) ovf_d = 1'b0;
    if (w_step && w_rc)          ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
    end
  end

  assign bus.q   = q_q;
  assign bus.rc  = w_rc;
  assign bus.ovf = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_mod_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_counter_mod_n
//  Description : Self-checking bench for counter_mod_n. Stages:
//                dut_a  MODULUS=10 wrap, dut_s MODULUS=10 saturate,
//                dut_m  MODULUS=16 wrap, dut_lo/dut_hi two cascaded
//                MODULUS=10 stages.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_counter_mod_n;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  counter_mod_n_if #(.WIDTH(4)) a_if ();
  counter_mod_n_if #(.WIDTH(4)) s_if ();
  counter_mod_n_if #(.WIDTH(4)) m_if ();
  counter_mod_n_if #(.WIDTH(4)) lo_if ();
  counter_mod_n_if #(.WIDTH(4)) hi_if ();

  counter_mod_n #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_a  (.clk(clk), .rst(rst), .bus(a_if));
  counter_mod_n #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_s  (.clk(clk), .rst(rst), .bus(s_if));
  counter_mod_n #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) dut_m  (.clk(clk), .rst(rst), .bus(m_if));
  counter_mod_n #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_lo (.clk(clk), .rst(rst), .bus(lo_if));
  counter_mod_n #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut_hi (.clk(clk), .rst(rst), .bus(hi_if));

  // Cascade: low stage carry feeds the high stage carry-in.
  assign hi_if.ci = lo_if.rc;

  typedef struct {
    logic       ce;
    logic       ci;
    logic       up;
    logic       load;
    logic [3:0] din;
    logic       clr;
    logic [3:0] exp_q;
    logic       exp_ovf;
    logic       exp_rc;
  } vec_t;

  vec_t vecs [27];

  function automatic vec_t mk(input logic ce, input logic ci, input logic up,
                              input logic ld, input logic [3:0] din, input logic clr,
                              input logic [3:0] q, input logic ovf, input logic rc);
    vec_t v;
    v.ce = ce; v.ci = ci; v.up = up; v.load = ld; v.din = din; v.clr = clr;
    v.exp_q = q; v.exp_ovf = ovf; v.exp_rc = rc;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int sq[4];
    int so[4];

    // Vector table for dut_a: inputs held across the edge, then q/ovf/rc
    // are checked with the same inputs still applied.
    //              ce ci up ld din  clr  q   ovf rc
    for (int i = 0; i < 8; i++)
      vecs[i] = mk(1, 1, 1, 0, 4'd0, 0, 4'(i + 1), 0, 0);     // 1..8
    vecs[8]  = mk(1, 1, 1, 0, 4'd0,  0, 4'd9, 0, 1);          // rc at 9
    vecs[9]  = mk(1, 1, 1, 0, 4'd0,  0, 4'd0, 1, 0);          // wrap, ovf
    vecs[10] = mk(1, 1, 1, 0, 4'd0,  0, 4'd1, 1, 0);
    vecs[11] = mk(1, 1, 1, 0, 4'd0,  0, 4'd2, 1, 0);
    vecs[12] = mk(1, 1, 1, 1, 4'd13, 0, 4'd9, 0, 1);          // clamp load
    vecs[13] = mk(1, 1, 1, 1, 4'd4,  0, 4'd4, 0, 0);          // load beats ce
    vecs[14] = mk(0, 1, 1, 1, 4'd3,  0, 4'd3, 0, 0);
    for (int i = 15; i < 20; i++)
      vecs[i] = mk(1, 0, 1, 0, 4'd0, 0, 4'd3, 0, 0);          // ci=0 holds
    vecs[20] = mk(1, 1, 0, 0, 4'd0,  0, 4'd2, 0, 0);          // down
    vecs[21] = mk(1, 1, 0, 0, 4'd0,  0, 4'd1, 0, 0);
    vecs[22] = mk(1, 1, 0, 0, 4'd0,  0, 4'd0, 0, 1);          // rc at 0 down
    vecs[23] = mk(1, 1, 0, 0, 4'd0,  0, 4'd9, 1, 0);          // down wrap
    vecs[24] = mk(1, 1, 1, 0, 4'd0,  0, 4'd0, 1, 0);          // dir change at 9
    vecs[25] = mk(0, 1, 1, 0, 4'd0,  1, 4'd0, 0, 0);          // ovf_clr
    vecs[26] = mk(1, 1, 0, 1, 4'd15, 0, 4'd9, 0, 0);          // clamp, up=0

    sq = '{1, 0, 0, 0};
    so = '{0, 0, 1, 1};

    a_if.ce = 0;  a_if.ci = 1;  a_if.up = 1;  a_if.load = 0;  a_if.din = 0;  a_if.ovf_clr = 0;
    s_if.ce = 0;  s_if.ci = 1;  s_if.up = 1;  s_if.load = 0;  s_if.din = 0;  s_if.ovf_clr = 0;
    m_if.ce = 0;  m_if.ci = 1;  m_if.up = 1;  m_if.load = 0;  m_if.din = 0;  m_if.ovf_clr = 0;
    lo_if.ce = 0; lo_if.ci = 1; lo_if.up = 1; lo_if.load = 0; lo_if.din = 0; lo_if.ovf_clr = 0;
    hi_if.ce = 0;               hi_if.up = 1; hi_if.load = 0; hi_if.din = 0; hi_if.ovf_clr = 0;

    // ---------------- reset ----------------
    rst = 1'b1;
    #12;
    chk("rst_a_q",   int'(a_if.q),  0);
    chk("rst_a_ovf", int'(a_if.ovf), 0);
    chk("rst_m_q",   int'(m_if.q),  0);
    chk("rst_hi_q",  int'(hi_if.q), 0);
    a_if.ce = 1; a_if.up = 0;
    #1 chk("rst_rc_down", int'(a_if.rc), 1);
    a_if.up = 1;
    #1 chk("rst_rc_up", int'(a_if.rc), 0);
    a_if.ce = 0;
    @(posedge clk);
    #3 rst = 1'b0;

    // ---------------- table on dut_a ----------------
    for (int i = 0; i < 27; i++) begin
      a_if.ce = vecs[i].ce;   a_if.ci = vecs[i].ci;     a_if.up = vecs[i].up;
      a_if.load = vecs[i].load; a_if.din = vecs[i].din; a_if.ovf_clr = vecs[i].clr;
      tick();
      chk($sformatf("vec%0d_q", i),   int'(a_if.q),   int'(vecs[i].exp_q));
      chk($sformatf("vec%0d_ovf", i), int'(a_if.ovf), int'(vecs[i].exp_ovf));
      chk($sformatf("vec%0d_rc", i),  int'(a_if.rc),  int'(vecs[i].exp_rc));
    end

    // ---------------- saturating down count ----------------
    s_if.load = 1; s_if.din = 4'd2; s_if.ce = 0;
    tick();
    chk("sat_load_q", int'(s_if.q), 2);
    s_if.load = 0; s_if.ce = 1; s_if.ci = 1; s_if.up = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("sat_dn%0d_q", i),   int'(s_if.q),   sq[i]);
      chk($sformatf("sat_dn%0d_ovf", i), int'(s_if.ovf), so[i]);
    end
    s_if.ovf_clr = 1;                        // step at 0 still a terminal event
    tick();
    chk("sat_clr_step_ovf", int'(s_if.ovf), 1);
    chk("sat_clr_step_q",   int'(s_if.q),   0);
    s_if.ce = 0;
    tick();
    chk("sat_clr_ovf", int'(s_if.ovf), 0);
    s_if.ovf_clr = 0; s_if.load = 1; s_if.din = 4'd9;
    tick();
    s_if.load = 0; s_if.ce = 1; s_if.up = 1;
    #1 chk("sat_rc_top", int'(s_if.rc), 1);
    tick();
    chk("sat_up_hold_q", int'(s_if.q),   9);
    chk("sat_up_ovf",    int'(s_if.ovf), 1);

    // ---------------- MODULUS=16 full-range wrap ----------------
    m_if.load = 1; m_if.din = 4'd15;
    tick();
    chk("m16_load_q", int'(m_if.q), 15);
    m_if.load = 0; m_if.ce = 1; m_if.up = 1;
    tick();
    chk("m16_wrap_q",   int'(m_if.q),   0);
    chk("m16_wrap_ovf", int'(m_if.ovf), 1);

    // ---------------- cascade 00..99 -> 00 ----------------
    lo_if.ce = 1; hi_if.ce = 1; lo_if.up = 1; hi_if.up = 1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      chk($sformatf("casc%0d", k), int'(hi_if.q) * 10 + int'(lo_if.q), k % 100);
    end
    chk("casc_hi_ovf", int'(hi_if.ovf), 1);
    chk("casc_lo_ovf", int'(lo_if.ovf), 1);
    lo_if.ce = 0; hi_if.ce = 0;

    // ---------------- async reset mid-count ----------------
    a_if.load = 1; a_if.din = 4'd9; a_if.ce = 0; a_if.up = 1; a_if.ci = 1;
    tick();
    a_if.load = 0; a_if.ce = 1;
    repeat (8) tick();                       // 9 -> 0 (ovf) -> ... -> 7
    chk("pre_rst_q",   int'(a_if.q),   7);
    chk("pre_rst_ovf", int'(a_if.ovf), 1);
    a_if.ce = 0;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_q",   int'(a_if.q),   0);
    chk("async_rst_ovf", int'(a_if.ovf), 0);
    #1 rst = 1'b0;
    a_if.ce = 1;
    tick();
    chk("post_rst_q", int'(a_if.q), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
